// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver. It decodes one byte per frame for the TensorFlowE byte input.
// It flags framing errors and ignores a held-low line until the line returns high.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx_serial,
    output logic [7:0] Datos_rx,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);
    localparam int HALF  = CLKS_PER_BIT / 2 - 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, state_d;
    logic             sync1, rx_s;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shreg, sh_d, data_d;
    logic             valid_d, ferr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            Datos_rx    <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sync1       <= rx_serial;
            rx_s        <= sync1;
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            shreg       <= sh_d;
            Datos_rx    <= data_d;
            rx_valid    <= valid_d;
            frame_error <= ferr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        sh_d    = shreg;
        data_d  = Datos_rx;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (!rx_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
                // Re-check the line at the start-bit centre to reject glitches
                START: if (cnt == HALF_C) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + ONE_C;
                end
                DATA: if (cnt == LAST_C) begin
                    sh_d  = {rx_s, shreg[7:1]};
                    cnt_d = '0;
                    idx_d = idx + 3'd1;
                    if (idx == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt + ONE_C;
                end
                STOP: if (cnt == LAST_C) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt + ONE_C;
                end
                BREAK: if (rx_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule
